// File: rtl/rca_config_loader.sv
// rca_config_loader: turns a packetised stream of 32-bit configuration words
// into single-cycle write strobes for the RCA configuration register file.
// A packet is one header word (target RCA, entry count) followed by that many
// entry words (kind, addr, data). All write-side outputs are registered.
module rca_config_loader #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 5,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int GRID_NUM_ROWS      = 4,
  parameter int NUM_GRID_MUXES     = 32,
  parameter int GRID_MUX_INPUTS    = 10,
  parameter int IO_UNIT_MUX_INPUTS = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [31:0]                           in_data,
  output logic                                  in_ready,
  output logic [$clog2(NUM_RCAS)-1:0]           rca_sel,
  output logic                                  cpu_fb_reg_addr_wr_en,
  output logic                                  cpu_nfb_reg_addr_wr_en,
  output logic [$clog2(NUM_READ_PORTS)-1:0]     cpu_port_sel,
  output logic                                  cpu_src_dest_port,
  output logic [4:0]                            cpu_reg_addr,
  output logic [$clog2(NUM_GRID_MUXES)-1:0]     grid_mux_addr,
  output logic                                  grid_mux_wr_en,
  output logic [$clog2(GRID_MUX_INPUTS)-1:0]    new_grid_mux_sel,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]      io_mux_addr,
  output logic                                  io_mux_wr_en,
  output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0] new_io_mux_sel,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0]    rca_result_mux_addr,
  output logic                                  rca_result_mux_wr_en,
  output logic [$clog2(GRID_NUM_ROWS)-1:0]      new_rca_result_mux_sel,
  output logic                                  rca_io_inp_use_wr_en,
  output logic [GRID_NUM_ROWS-1:0]              new_rca_io_inp_use,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error
);

  localparam int RCA_W  = $clog2(NUM_RCAS);
  localparam int PORT_W = $clog2(NUM_READ_PORTS);
  localparam int GMA_W  = $clog2(NUM_GRID_MUXES);
  localparam int GMS_W  = $clog2(GRID_MUX_INPUTS);
  localparam int IOA_W  = $clog2(GRID_NUM_ROWS);
  localparam int IOS_W  = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int RMA_W  = $clog2(NUM_WRITE_PORTS);
  localparam int RMS_W  = $clog2(GRID_NUM_ROWS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_rca_bad;

  logic        w_hdr_acc;
  logic        w_ent_acc;
  logic        w_last_ent;
  logic        w_hdr_bad_rca;
  logic [3:0]  w_kind;
  logic [11:0] w_addr;
  logic [15:0] w_data;
  logic        w_fb_src_ok;
  logic        w_fb_dst_ok;
  logic        w_nfb_ok;
  logic        w_grid_ok;
  logic        w_io_ok;
  logic        w_res_ok;
  logic        w_use_ok;
  logic        w_ent_bad;
  logic        w_issue;
  logic        w_nxt_load;
  logic        w_nxt_any_strobe;

  // Both states take a word every cycle; only reset holds the stream off.
  assign in_ready = ~rst;

  assign w_hdr_acc     = in_valid & in_ready & (r_state == ST_IDLE);
  assign w_ent_acc     = in_valid & in_ready & (r_state == ST_LOAD);
  assign w_last_ent    = w_ent_acc & (r_count == 8'd1);
  assign w_hdr_bad_rca = (in_data[7:0] >= 8'(NUM_RCAS));
  assign w_kind        = in_data[3:0];
  assign w_addr        = in_data[15:4];
  assign w_data        = in_data[31:16];
  // Entries of a packet aimed at a non-existent RCA are swallowed silently.
  assign w_issue       = w_ent_acc & ~r_rca_bad;

  // Decode the entry kind and range-check its addr/data fields.
  always_comb begin
    w_fb_src_ok = 1'b0;
    w_fb_dst_ok = 1'b0;
    w_nfb_ok    = 1'b0;
    w_grid_ok   = 1'b0;
    w_io_ok     = 1'b0;
    w_res_ok    = 1'b0;
    w_use_ok    = 1'b0;
    w_ent_bad   = 1'b0;
    case (w_kind)
      4'd0: begin
        if (w_addr < 12'(NUM_READ_PORTS)) w_fb_src_ok = 1'b1;
        else                              w_ent_bad   = 1'b1;
      end
      4'd1: begin
        if (w_addr < 12'(NUM_WRITE_PORTS)) w_fb_dst_ok = 1'b1;
        else                               w_ent_bad   = 1'b1;
      end
      4'd2: begin
        if (w_addr < 12'(NUM_WRITE_PORTS)) w_nfb_ok  = 1'b1;
        else                               w_ent_bad = 1'b1;
      end
      4'd3: begin
        if ((w_addr < 12'(NUM_GRID_MUXES)) && (w_data < 16'(GRID_MUX_INPUTS))) w_grid_ok = 1'b1;
        else                                                                   w_ent_bad = 1'b1;
      end
      4'd4: begin
        if ((w_addr < 12'(GRID_NUM_ROWS)) && (w_data < 16'(IO_UNIT_MUX_INPUTS))) w_io_ok   = 1'b1;
        else                                                                     w_ent_bad = 1'b1;
      end
      4'd5: begin
        if ((w_addr < 12'(NUM_WRITE_PORTS)) && (w_data < 16'(GRID_NUM_ROWS))) w_res_ok  = 1'b1;
        else                                                                  w_ent_bad = 1'b1;
      end
      4'd6:    w_use_ok  = 1'b1;
      default: w_ent_bad = 1'b1;
    endcase
  end

  // Next-cycle view of busy: still loading, or a strobe about to fire.
  always_comb begin
    w_nxt_any_strobe = w_issue & (w_fb_src_ok | w_fb_dst_ok | w_nfb_ok | w_grid_ok |
                                  w_io_ok | w_res_ok | w_use_ok);
    if (r_state == ST_LOAD) begin
      w_nxt_load = ~w_last_ent;
    end else begin
      w_nxt_load = w_hdr_acc & (in_data[15:8] != 8'd0);
    end
  end

  // Packet sequencer plus all registered write-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                <= ST_IDLE;
      r_count                <= 8'd0;
      r_rca_bad              <= 1'b0;
      rca_sel                <= '0;
      cpu_fb_reg_addr_wr_en  <= 1'b0;
      cpu_nfb_reg_addr_wr_en <= 1'b0;
      cpu_port_sel           <= '0;
      cpu_src_dest_port      <= 1'b0;
      cpu_reg_addr           <= 5'd0;
      grid_mux_addr          <= '0;
      grid_mux_wr_en         <= 1'b0;
      new_grid_mux_sel       <= '0;
      io_mux_addr            <= '0;
      io_mux_wr_en           <= 1'b0;
      new_io_mux_sel         <= '0;
      rca_result_mux_addr    <= '0;
      rca_result_mux_wr_en   <= 1'b0;
      new_rca_result_mux_sel <= '0;
      rca_io_inp_use_wr_en   <= 1'b0;
      new_rca_io_inp_use     <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
    end else begin
      cpu_fb_reg_addr_wr_en  <= w_issue & (w_fb_src_ok | w_fb_dst_ok);
      cpu_nfb_reg_addr_wr_en <= w_issue & w_nfb_ok;
      grid_mux_wr_en         <= w_issue & w_grid_ok;
      io_mux_wr_en           <= w_issue & w_io_ok;
      rca_result_mux_wr_en   <= w_issue & w_res_ok;
      rca_io_inp_use_wr_en   <= w_issue & w_use_ok;
      busy                   <= w_nxt_load | w_nxt_any_strobe;
      done                   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_hdr_acc) begin
            rca_sel   <= in_data[RCA_W-1:0];
            r_count   <= in_data[15:8];
            r_rca_bad <= w_hdr_bad_rca;
            error     <= w_hdr_bad_rca;
            if (in_data[15:8] == 8'd0) begin
              done <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_ent_acc) begin
            r_count <= r_count - 8'd1;
            if (w_ent_bad) begin
              error <= 1'b1;
            end
            if (w_last_ent) begin
              r_state <= ST_IDLE;
              done    <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Address/data fields only move when their strobe fires; otherwise hold.
      if (w_issue & (w_fb_src_ok | w_fb_dst_ok | w_nfb_ok)) begin
        cpu_port_sel      <= w_addr[PORT_W-1:0];
        cpu_src_dest_port <= ~w_fb_src_ok;
        cpu_reg_addr      <= w_data[4:0];
      end
      if (w_issue & w_grid_ok) begin
        grid_mux_addr    <= w_addr[GMA_W-1:0];
        new_grid_mux_sel <= w_data[GMS_W-1:0];
      end
      if (w_issue & w_io_ok) begin
        io_mux_addr    <= w_addr[IOA_W-1:0];
        new_io_mux_sel <= w_data[IOS_W-1:0];
      end
      if (w_issue & w_res_ok) begin
        rca_result_mux_addr    <= w_addr[RMA_W-1:0];
        new_rca_result_mux_sel <= w_data[RMS_W-1:0];
      end
      if (w_issue & w_use_ok) begin
        new_rca_io_inp_use <= w_data[GRID_NUM_ROWS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rca_config_loader.sv
// Directed testbench for rca_config_loader with hand-computed expectations.
module tb_rca_config_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [1:0]  rca_sel;
  logic        fb_we, nfb_we, grid_we, io_we, res_we, use_we;
  logic [2:0]  port_sel;
  logic        src_dest;
  logic [4:0]  reg_addr;
  logic [4:0]  grid_addr;
  logic [3:0]  grid_sel;
  logic [1:0]  io_addr;
  logic [2:0]  io_sel;
  logic [0:0]  res_addr;
  logic [1:0]  res_sel;
  logic [3:0]  inp_use;
  logic        busy, done, error;

  logic [5:0]  strb;
  logic [40:0] all_out;
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_fail  = 0;
  int          strobe_cnt = 0;
  int          rule_viol  = 0;
  int          snap;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_FB   = 6'b100000;
  localparam logic [5:0] S_NFB  = 6'b010000;
  localparam logic [5:0] S_GRID = 6'b001000;
  localparam logic [5:0] S_IO   = 6'b000100;
  localparam logic [5:0] S_RES  = 6'b000010;
  localparam logic [5:0] S_USE  = 6'b000001;

  localparam logic [31:0] HDR_R2N3 = 32'h0000_0302;
  localparam logic [31:0] E_FB     = 32'h000A_0010;
  localparam logic [31:0] E_NFB    = 32'h001F_0002;
  localparam logic [31:0] E_GRID   = 32'h0007_0053;

  assign strb    = {fb_we, nfb_we, grid_we, io_we, res_we, use_we};
  assign all_out = {rca_sel, fb_we, nfb_we, port_sel, src_dest, reg_addr, grid_addr, grid_we,
                    grid_sel, io_addr, io_we, io_sel, res_addr, res_we, res_sel, use_we, inp_use,
                    busy, done, error};

  rca_config_loader dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_ready               (in_ready),
    .rca_sel                (rca_sel),
    .cpu_fb_reg_addr_wr_en  (fb_we),
    .cpu_nfb_reg_addr_wr_en (nfb_we),
    .cpu_port_sel           (port_sel),
    .cpu_src_dest_port      (src_dest),
    .cpu_reg_addr           (reg_addr),
    .grid_mux_addr          (grid_addr),
    .grid_mux_wr_en         (grid_we),
    .new_grid_mux_sel       (grid_sel),
    .io_mux_addr            (io_addr),
    .io_mux_wr_en           (io_we),
    .new_io_mux_sel         (io_sel),
    .rca_result_mux_addr    (res_addr),
    .rca_result_mux_wr_en   (res_we),
    .new_rca_result_mux_sel (res_sel),
    .rca_io_inp_use_wr_en   (use_we),
    .new_rca_io_inp_use     (inp_use),
    .busy                   (busy),
    .done                   (done),
    .error                  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes and record strobe-exclusivity violations mid-cycle.
  always @(negedge clk) begin
    strobe_cnt = strobe_cnt + $countones(strb);
    if ($countones(strb) > 1) rule_viol = rule_viol + 1;
    if (nfb_we && (fb_we || !src_dest)) rule_viol = rule_viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0;
    tick(); tick();
    chk("reset_outputs", 64'(all_out), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // Basic packet: rca 2, three back-to-back entries.
    snap = strobe_cnt;
    send(1'b1, HDR_R2N3);
    chk("hdr_busy", 64'(busy), 64'd1);
    chk("hdr_rca", 64'(rca_sel), 64'd2);
    chk("hdr_strb", 64'(strb), 64'(S_NONE));
    send(1'b1, E_FB);
    chk("fb_strb", 64'(strb), 64'(S_FB));
    chk("fb_fields", 64'({port_sel, src_dest, reg_addr}), 64'({3'd1, 1'b0, 5'd10}));
    chk("fb_done", 64'(done), 64'd0);
    send(1'b1, E_NFB);
    chk("nfb_strb", 64'(strb), 64'(S_NFB));
    chk("nfb_fields", 64'({port_sel, src_dest, reg_addr}), 64'({3'd0, 1'b1, 5'd31}));
    send(1'b1, E_GRID);
    chk("grid_strb", 64'(strb), 64'(S_GRID));
    chk("grid_fields", 64'({grid_addr, grid_sel}), 64'({5'd5, 4'd7}));
    chk("grid_done_busy_err_rca", 64'({done, busy, error, rca_sel}), 64'({1'b1, 1'b1, 1'b0, 2'd2}));
    send(1'b0, 32'd0);
    chk("post_pkt", 64'({strb, done, busy}), 64'({S_NONE, 1'b0, 1'b0}));
    chk("grid_hold", 64'({grid_addr, grid_sel}), 64'({5'd5, 4'd7}));
    chk("pkt1_strobes", 64'(strobe_cnt - snap), 64'd3);

    // Same packet with two idle cycles between entries.
    snap = strobe_cnt;
    send(1'b1, HDR_R2N3);
    send(1'b1, E_FB);
    chk("st_fb", 64'({strb, port_sel, reg_addr}), 64'({S_FB, 3'd1, 5'd10}));
    send(1'b0, 32'd0);
    chk("st_gap1", 64'({strb, busy, done, port_sel}), 64'({S_NONE, 1'b1, 1'b0, 3'd1}));
    send(1'b0, 32'd0);
    chk("st_gap2", 64'({strb, busy}), 64'({S_NONE, 1'b1}));
    send(1'b1, E_NFB);
    chk("st_nfb", 64'({strb, port_sel, src_dest, reg_addr}), 64'({S_NFB, 3'd0, 1'b1, 5'd31}));
    send(1'b0, 32'd0);
    send(1'b0, 32'd0);
    chk("st_gap4", 64'({strb, busy, done}), 64'({S_NONE, 1'b1, 1'b0}));
    send(1'b1, E_GRID);
    chk("st_grid", 64'({strb, grid_addr, grid_sel, done}), 64'({S_GRID, 5'd5, 4'd7, 1'b1}));
    send(1'b0, 32'd0);
    chk("st_idle", 64'({busy, done}), 64'd0);
    chk("st_strobes", 64'(strobe_cnt - snap), 64'd3);

    // Grid select out of range: no strobe, error set, done still pulses.
    snap = strobe_cnt;
    send(1'b1, 32'h0000_0101);
    chk("rng_hdr_err", 64'(error), 64'd0);
    send(1'b1, 32'h000C_0003);
    chk("rng_entry", 64'({strb, error, done, busy}), 64'({S_NONE, 1'b1, 1'b1, 1'b0}));
    send(1'b0, 32'd0);
    chk("rng_sticky", 64'({error, done}), 64'({1'b1, 1'b0}));

    // Empty packet: done next cycle, clears error, never busy.
    send(1'b1, 32'h0000_0000);
    chk("n0_done", 64'({done, error, busy, strb, rca_sel}), 64'({1'b1, 1'b0, 1'b0, S_NONE, 2'd0}));
    send(1'b0, 32'd0);
    chk("n0_after", 64'({done, busy}), 64'd0);

    // Illegal kind 7.
    send(1'b1, 32'h0000_0101);
    send(1'b1, 32'h0000_0017);
    chk("kind7", 64'({strb, error, done}), 64'({S_NONE, 1'b1, 1'b1}));

    // Bad RCA id: entries swallowed without strobes.
    send(1'b1, 32'h0000_0205);
    chk("badrca_hdr", 64'({error, busy}), 64'({1'b1, 1'b1}));
    send(1'b1, E_FB);
    chk("badrca_e1", 64'({strb, done}), 64'({S_NONE, 1'b0}));
    send(1'b1, E_NFB);
    chk("badrca_e2", 64'({strb, done, error}), 64'({S_NONE, 1'b1, 1'b1}));
    send(1'b0, 32'd0);
    chk("badrca_idle", 64'(busy), 64'd0);
    chk("err_strobes", 64'(strobe_cnt - snap), 64'd0);

    // Read-port boundary: fb src port 4 legal, fb dest port 2 illegal.
    send(1'b1, 32'h0000_0200);
    chk("bnd_hdr_err", 64'(error), 64'd0);
    send(1'b1, 32'h0009_0040);
    chk("bnd_src4", 64'({strb, port_sel, src_dest, reg_addr, error}), 64'({S_FB, 3'd4, 1'b0, 5'd9, 1'b0}));
    send(1'b1, 32'h0009_0021);
    chk("bnd_dst2", 64'({strb, error, done, port_sel}), 64'({S_NONE, 1'b1, 1'b1, 3'd4}));

    // Result mux and IO input-use writes.
    send(1'b1, 32'h0000_0203);
    chk("k56_rca", 64'({rca_sel, error}), 64'({2'd3, 1'b0}));
    send(1'b1, 32'h0002_0015);
    chk("res_strb", 64'({strb, res_addr, res_sel}), 64'({S_RES, 1'b1, 2'd2}));
    send(1'b1, 32'h000A_0006);
    chk("use_strb", 64'({strb, inp_use, done}), 64'({S_USE, 4'hA, 1'b1}));
    send(1'b0, 32'd0);

    // Reset in the middle of a packet.
    send(1'b1, HDR_R2N3);
    send(1'b1, E_FB);
    chk("mid_fb", 64'(strb), 64'(S_FB));
    rst = 1'b1; in_data = E_NFB;
    tick();
    chk("mid_rst_outputs", 64'(all_out), 64'd0);
    snap = strobe_cnt;
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("mid_rst_quiet", 64'({strobe_cnt - snap, 32'(all_out[2:0])}), 64'd0);
    send(1'b1, 32'h0000_0101);
    send(1'b1, 32'h0003_0024);
    chk("post_rst_io", 64'({strb, io_addr, io_sel, done, rca_sel}), 64'({S_IO, 2'd2, 3'd3, 1'b1, 2'd1}));
    send(1'b0, 32'd0);

    chk("strobe_rules", 64'(rule_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
